lut_gate: RTL and testbench
===========================

Name: lut_gate

Overview:
- Parametrised, registered successor to the fixed 4-input case gate.
- Evaluates an N_IN-input Boolean function from a truth table held in registers.
- Table is reprogrammable at run time over a serial config port; evaluation continues uninterrupted during a reload.
- Sits between input-sampling logic and downstream consumers; uses a valid/ready handshake on both data sides.

Parameters:
- N_IN, 4, number of function inputs; legal 1..8.
- INIT, 16'h7777, reset truth table, 2**N_IN bits.
  - Bit i is F for input vector i.
  - Default gives F=0 exactly when IN_DATA[1:0]==2'b11.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  IN_DATA valid.
- IN_DATA  in  N_IN  input vector; bit N_IN-1 is the MSB (A in the 4-input case).
- IN_READY  out  1  block can accept IN_DATA this cycle.
- F  out  1  function result.
- F_VALID  out  1  F valid.
- F_READY  in  1  consumer accepts F.
- CFG_START  in  1  begin table load; CFG_BIT in the same cycle is table bit 0.
- CFG_BIT  in  1  serial table bit, index order 0..2**N_IN-1.
- CFG_ABORT  in  1  cancel load in progress.
- CFG_BUSY  out  1  load in progress.
- CFG_DONE  out  1  one-cycle pulse when the new table is committed.

Behaviour:
- Reset (async assert, synchronous-to-CLK deassert handled upstream):
  - Active table = INIT; shadow table = 0; bit counter = 0; state = IDLE.
  - F=0, F_VALID=0, CFG_BUSY=0, CFG_DONE=0.
- Data path (1-entry output register):
  - IN_READY = !F_VALID || F_READY (combinational).
  - Accept when IN_VALID && IN_READY. At that edge: F <= active_table[IN_DATA], F_VALID <= 1.
  - Latency is 1 cycle. Full throughput is sustained when F_READY stays 1.
  - F_VALID && !F_READY: F and F_VALID hold stable, IN_READY=0, no input is consumed.
  - F_VALID && F_READY && !(IN_VALID && IN_READY): F_VALID <= 0; F holds its last value.
- Config FSM, states IDLE and LOAD:
  - IDLE: CFG_START=1 -> shadow[0] <= CFG_BIT, counter <= 1, go to LOAD.
  - LOAD, each cycle without abort: shadow[counter] <= CFG_BIT, counter++.
  - Final bit (counter == 2**N_IN-1): active table <= shadow with this bit merged, counter <= 0, CFG_DONE=1 for that next cycle, go to IDLE.
  - Load length is exactly 2**N_IN cycles including the START cycle.
  - CFG_BUSY=1 in every LOAD cycle, i.e. cycles 2..2**N_IN of the load.
  - CFG_START in LOAD is ignored.
  - N_IN=1: the load completes in 2 cycles. START captures bit 0 and enters LOAD; the next cycle captures bit 1 and commits.
- Abort:
  - CFG_ABORT in LOAD: bit not captured, shadow discarded, counter <= 0, active table unchanged, go to IDLE, no CFG_DONE.
  - CFG_ABORT in IDLE: ignored.
  - CFG_ABORT and CFG_START together in IDLE: START wins.
- Commit/lookup collision: a lookup accepted on the commit edge uses the old table. The first lookup using the new table is the one accepted on the edge after commit.
- Reset mid-load: the table reverts to INIT and any partial load is lost.
- Reset with F_VALID=1: the pending result is dropped.
- Width rule: table index is IN_DATA zero-extended to N_IN bits. The counter is N_IN bits wide (minimum 1) and wraps only via an explicit clear.

Decomposition:
- lut_gate_pkg contains:
  - cfg_state_t enum {CFG_IDLE, CFG_LOAD};
  - localparam function tbl_width(n) = 2**n;
  - constant DEFAULT_INIT4 = 16'h7777.
- One sub-module, lut_cfg_loader:
  - contains the FSM, bit counter, shadow register, commit strobe and CFG_BUSY/CFG_DONE;
  - outputs a commit pulse plus the full table value.
- Top level holds the active table, the lookup mux and the output handshake register.

Test Plan:
- Post-reset sweep, N_IN=4, F_READY=1, IN_DATA=0..15 one per cycle:
  - F is 0 for 3,7,11,15 and 1 for all other inputs;
  - each F appears 1 cycle after its input;
  - F_VALID stays continuously high.
- Backpressure: IN_DATA=3 accepted, F_READY=0 for 3 cycles, then 1:
  - F=0 and F_VALID=1 hold throughout;
  - IN_READY=0 until release;
  - the next input is accepted on the release edge.
- Serial load of 16'h8000 (AND4):
  - CFG_BUSY is high for 15 cycles;
  - CFG_DONE pulses once;
  - sweep gives F=1 only at 4'b1111.
- Collision: last config bit and IN_DATA=4'b1111 on the same edge, with old table INIT and new table 16'h0000:
  - that lookup returns F=0 (old table: INIT[15]=0);
  - IN_DATA=0 on the next edge returns F=0 (new table; old table would give 1).
- Abort after 5 bits of 16'h0000, then sweep:
  - results match INIT;
  - no CFG_DONE pulse;
  - a following full load succeeds.
- RST_N pulsed low mid-load, and again with F_VALID=1:
  - outputs clear immediately (asynchronously);
  - the table equals INIT after release.

Source files
------------

// File: rtl/lut_gate_pkg.sv
// Shared types and constants for the run-time programmable lookup gate.
package lut_gate_pkg;

  typedef enum logic {
    CFG_IDLE,
    CFG_LOAD
  } cfg_state_t;

  function automatic int unsigned tbl_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

  localparam logic [15:0] DEFAULT_INIT4 = 16'h7777;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial truth-table loader: shadow register, bit counter and commit strobe.
module lut_cfg_loader
  import lut_gate_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic                       cfg_bit,
  input  logic                       cfg_abort,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       commit,
  output logic [tbl_width(N_IN)-1:0] table_val
);

  localparam int unsigned TW = tbl_width(N_IN);
  localparam logic [N_IN-1:0] CNT_LAST = N_IN'(TW - 1);

  cfg_state_t      state;
  logic [N_IN-1:0] cnt;
  logic [TW-1:0]   shadow;

  // Commit is combinational so the active table updates on the final-bit edge itself.
  assign commit = (state == CFG_LOAD) && !cfg_abort && (cnt == CNT_LAST);

  always_comb begin
    table_val      = shadow;
    table_val[cnt] = cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CFG_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        CFG_IDLE: begin
          if (cfg_start) begin
            shadow    <= '0;
            shadow[0] <= cfg_bit;
            cnt       <= N_IN'(1);
            state     <= CFG_LOAD;
            cfg_busy  <= 1'b1;
          end
        end
        CFG_LOAD: begin
          if (cfg_abort) begin
            shadow   <= '0;
            cnt      <= '0;
            state    <= CFG_IDLE;
            cfg_busy <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            shadow   <= table_val;
            cnt      <= '0;
            state    <= CFG_IDLE;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b1;
          end else begin
            shadow[cnt] <= cfg_bit;
            cnt         <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= CFG_IDLE;
          cnt      <= '0;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lut_gate.sv
// Registered N_IN-input Boolean function evaluated from a reloadable truth table.
module lut_gate
  import lut_gate_pkg::*;
#(
  parameter int unsigned                  N_IN = 4,
  parameter logic [tbl_width(N_IN)-1:0]   INIT = DEFAULT_INIT4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  input  logic [N_IN-1:0] IN_DATA,
  output logic            IN_READY,
  output logic            F,
  output logic            F_VALID,
  input  logic            F_READY,
  input  logic            CFG_START,
  input  logic            CFG_BIT,
  input  logic            CFG_ABORT,
  output logic            CFG_BUSY,
  output logic            CFG_DONE
);

  localparam int unsigned TW = tbl_width(N_IN);

  logic [TW-1:0] active_tbl;
  logic [TW-1:0] new_tbl;
  logic          commit;
  logic          accept;

  lut_cfg_loader #(.N_IN(N_IN)) u_cfg (
    .clk       (CLK),
    .rst_n     (RST_N),
    .cfg_start (CFG_START),
    .cfg_bit   (CFG_BIT),
    .cfg_abort (CFG_ABORT),
    .cfg_busy  (CFG_BUSY),
    .cfg_done  (CFG_DONE),
    .commit    (commit),
    .table_val (new_tbl)
  );

  assign IN_READY = !F_VALID || F_READY;
  assign accept   = IN_VALID && IN_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      active_tbl <= INIT;
    end else if (commit) begin
      active_tbl <= new_tbl;
    end
  end

  // Lookup reads the pre-commit table, so a collision on the commit edge sees the old function.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      F       <= 1'b0;
      F_VALID <= 1'b0;
    end else if (accept) begin
      F       <= active_tbl[IN_DATA];
      F_VALID <= 1'b1;
    end else if (F_READY) begin
      F_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_gate.sv
// Self-checking bench for lut_gate: vector sweeps, hand sequences and a randomized model run.
module tb_lut_gate;
  import lut_gate_pkg::*;

  localparam int unsigned N = 4;
  localparam logic [15:0] INIT_T = 16'h7777;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [3:0] IN_DATA = '0;
  logic       IN_READY;
  logic       F;
  logic       F_VALID;
  logic       F_READY = 1'b1;
  logic       CFG_START = 1'b0;
  logic       CFG_BIT = 1'b0;
  logic       CFG_ABORT = 1'b0;
  logic       CFG_BUSY;
  logic       CFG_DONE;

  always #5 CLK = ~CLK;

  lut_gate #(.N_IN(N), .INIT(INIT_T)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_DATA   (IN_DATA),
    .IN_READY  (IN_READY),
    .F         (F),
    .F_VALID   (F_VALID),
    .F_READY   (F_READY),
    .CFG_START (CFG_START),
    .CFG_BIT   (CFG_BIT),
    .CFG_ABORT (CFG_ABORT),
    .CFG_BUSY  (CFG_BUSY),
    .CFG_DONE  (CFG_DONE)
  );

  typedef struct {
    logic [3:0] d;
    logic       f_init;
    logic       f_and4;
  } vec_t;

  vec_t vecs[16];

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Reference model state: table, output register, and load progress as a bit count.
  logic [15:0] m_tbl;
  logic        m_f;
  logic        m_fv;
  logic        m_loading;
  int          m_pos;
  logic [15:0] m_bits;
  logic        m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tbl     = INIT_T;
    m_f       = 1'b0;
    m_fv      = 1'b0;
    m_loading = 1'b0;
    m_pos     = 0;
    m_bits    = '0;
    m_done    = 1'b0;
  endtask

  // One clock: check IN_READY, advance the model with the applied inputs, then check outputs.
  task automatic tick();
    logic acc;
    #1;
    chk("in_ready", {31'd0, IN_READY}, {31'd0, (!m_fv || F_READY)});
    acc = IN_VALID && (!m_fv || F_READY);
    if (acc) begin
      m_f  = m_tbl[IN_DATA];
      m_fv = 1'b1;
    end else if (m_fv && F_READY) begin
      m_fv = 1'b0;
    end
    m_done = 1'b0;
    if (!m_loading) begin
      if (CFG_START) begin
        m_bits    = '0;
        m_bits[0] = CFG_BIT;
        m_pos     = 1;
        m_loading = 1'b1;
      end
    end else if (CFG_ABORT) begin
      m_loading = 1'b0;
      m_pos     = 0;
    end else begin
      m_bits[m_pos] = CFG_BIT;
      m_pos++;
      if (m_pos == 16) begin
        m_tbl     = m_bits;
        m_done    = 1'b1;
        m_loading = 1'b0;
        m_pos     = 0;
      end
    end
    @(posedge CLK);
    #1;
    chk("f", {31'd0, F}, {31'd0, m_f});
    chk("f_valid", {31'd0, F_VALID}, {31'd0, m_fv});
    chk("cfg_busy", {31'd0, CFG_BUSY}, {31'd0, m_loading});
    chk("cfg_done", {31'd0, CFG_DONE}, {31'd0, m_done});
    busy_cnt += int'(CFG_BUSY);
    done_cnt += int'(CFG_DONE);
  endtask

  task automatic idle_inputs();
    IN_VALID  = 1'b0;
    CFG_START = 1'b0;
    CFG_ABORT = 1'b0;
    CFG_BIT   = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    RST_N = 1'b0;
    #1;
    chk({tag, "_f"}, {31'd0, F}, 32'd0);
    chk({tag, "_fv"}, {31'd0, F_VALID}, 32'd0);
    chk({tag, "_busy"}, {31'd0, CFG_BUSY}, 32'd0);
    chk({tag, "_done"}, {31'd0, CFG_DONE}, 32'd0);
    model_reset();
    idle_inputs();
    #1;
    RST_N = 1'b1;
  endtask

  task automatic sweep(input bit and4);
    F_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = vecs[i].d;
      tick();
      chk(and4 ? "sweep_and4" : "sweep_init", {31'd0, F},
          {31'd0, (and4 ? vecs[i].f_and4 : vecs[i].f_init)});
      chk("sweep_fv", {31'd0, F_VALID}, 32'd1);
    end
    IN_VALID = 1'b0;
    tick();
  endtask

  task automatic cfg_load(input logic [15:0] val, input int abort_at, input bit collide);
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == abort_at) begin
        CFG_START = 1'b0;
        CFG_ABORT = 1'b1;
        tick();
        CFG_ABORT = 1'b0;
        break;
      end
      CFG_START = (k == 0);
      CFG_BIT   = val[k];
      if (collide && k == 15) begin
        IN_VALID = 1'b1;
        IN_DATA  = 4'hF;
      end
      tick();
      if (collide && k == 15) begin
        chk("collide_old_tbl", {31'd0, F}, 32'd0);
        IN_DATA = 4'h0;
      end
    end
    CFG_START = 1'b0;
    CFG_BIT   = 1'b0;
    tick();
    if (collide) begin
      chk("collide_new_tbl", {31'd0, F}, 32'd0);
      IN_VALID = 1'b0;
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].d      = 4'(i);
      vecs[i].f_init = (i % 4) != 3;
      vecs[i].f_and4 = (i == 15);
    end
    model_reset();

    #12;
    chk("rst_f", {31'd0, F}, 32'd0);
    chk("rst_fv", {31'd0, F_VALID}, 32'd0);
    chk("rst_busy", {31'd0, CFG_BUSY}, 32'd0);
    chk("rst_done", {31'd0, CFG_DONE}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    sweep(1'b0);

    // Backpressure: result for input 3 held while consumer stalls.
    IN_VALID = 1'b1;
    IN_DATA  = 4'd3;
    tick();
    F_READY = 1'b0;
    IN_DATA = 4'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_f_hold", {31'd0, F}, 32'd0);
      chk("bp_fv_hold", {31'd0, F_VALID}, 32'd1);
      chk("bp_in_ready", {31'd0, IN_READY}, 32'd0);
    end
    F_READY = 1'b1;
    tick();
    chk("bp_release_f", {31'd0, F}, 32'd1);
    IN_VALID = 1'b0;
    tick();

    cfg_load(16'h8000, -1, 1'b0);
    chk("and4_busy_cycles", busy_cnt, 32'd15);
    chk("and4_done_pulses", done_cnt, 32'd1);
    sweep(1'b1);

    pulse_reset("rst_a");
    tick();
    cfg_load(16'h0000, -1, 1'b1);
    chk("collide_done", done_cnt, 32'd1);

    pulse_reset("rst_b");
    tick();
    cfg_load(16'h0000, 5, 1'b0);
    chk("abort_busy_cycles", busy_cnt, 32'd5);
    chk("abort_no_done", done_cnt, 32'd0);
    sweep(1'b0);
    cfg_load(16'hA5C3, -1, 1'b0);
    chk("reload_done", done_cnt, 32'd1);

    for (int c = 0; c < 500; c++) begin
      IN_VALID  = $urandom_range(0, 1) == 1;
      IN_DATA   = 4'($urandom_range(0, 15));
      F_READY   = $urandom_range(0, 3) != 0;
      CFG_START = $urandom_range(0, 9) == 0;
      CFG_ABORT = $urandom_range(0, 39) == 0;
      CFG_BIT   = $urandom_range(0, 1) == 1;
      tick();
    end
    idle_inputs();
    F_READY = 1'b1;
    tick();

    // Reset mid-load, then reset with a pending result.
    cfg_load(16'h0000, -1, 1'b0);
    CFG_START = 1'b1;
    CFG_BIT   = 1'b1;
    tick();
    CFG_START = 1'b0;
    tick();
    tick();
    pulse_reset("rst_midload");
    tick();
    sweep(1'b0);
    F_READY  = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 4'd0;
    tick();
    chk("pending_fv", {31'd0, F_VALID}, 32'd1);
    pulse_reset("rst_pending");
    F_READY = 1'b1;
    tick();
    sweep(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
